// File: rtl/tpu_pkg.sv
// Shared types and default sizing for the matrix multiply-accumulate engine.
package tpu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mac_state_t;

  localparam int TPU_BITS_AB = 16;
  localparam int TPU_BITS_C  = 32;
  localparam int TPU_DIM     = 32;

endpackage

// File: rtl/tpu_mac_engine_if.sv
// Command/response bundle between the execute stage (master) and the MAC engine (slave).
interface tpu_mac_engine_if
  import tpu_pkg::*;
#(
  parameter int DIM = TPU_DIM
) ();

  localparam int IW = $clog2(DIM);

  logic          start_i;
  logic          wr_en_a_i;
  logic          wr_en_b_i;
  logic          wr_en_c_i;
  logic [IW-1:0] row_i;
  logic [IW-1:0] col_i;
  logic [31:0]   data_i;
  logic [31:0]   data_o;
  logic          done_o;
  logic          busy_o;

  modport master (
    output start_i, wr_en_a_i, wr_en_b_i, wr_en_c_i, row_i, col_i, data_i,
    input  data_o, done_o, busy_o
  );

  modport slave (
    input  start_i, wr_en_a_i, wr_en_b_i, wr_en_c_i, row_i, col_i, data_i,
    output data_o, done_o, busy_o
  );

endinterface

// File: rtl/tpu_mac.sv
// Combinational signed multiply followed by a wrapping accumulate into BITS_C bits.
module tpu_mac
  import tpu_pkg::*;
#(
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int BITS_C  = TPU_BITS_C
) (
  input  logic signed [BITS_AB-1:0] a,
  input  logic signed [BITS_AB-1:0] b,
  input  logic signed [BITS_C-1:0]  acc,
  output logic signed [BITS_C-1:0]  acc_next
);

  // Full-precision product is sign-extended or truncated to the accumulator width.
  function automatic logic signed [BITS_C-1:0] fit_c(input logic signed [2*BITS_AB-1:0] p);
    return BITS_C'(p);
  endfunction

  logic signed [2*BITS_AB-1:0] prod;

  always_comb begin
    prod     = (2*BITS_AB)'(a) * (2*BITS_AB)'(b);
    acc_next = acc + fit_c(prod);
  end

endmodule

// File: rtl/tpu_mac_engine.sv
// Operand/accumulator storage plus a sequencer that runs C += A*B, one MAC per cycle.
module tpu_mac_engine
  import tpu_pkg::*;
#(
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int BITS_C  = TPU_BITS_C,
  parameter int DIM     = TPU_DIM
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  tpu_mac_engine_if.slave  bus
);

  localparam int IW = $clog2(DIM);
  localparam int CW = 3 * IW;

  mac_state_t state, state_next;

  // {i, j, k} packed so a single increment walks k fastest, then j, then i.
  logic [CW-1:0] ctr;
  logic [IW-1:0] i_idx, j_idx, k_idx;
  logic          last_mac;
  logic          done_q;

  logic signed [BITS_AB-1:0] a_mem [DIM][DIM];
  logic signed [BITS_AB-1:0] b_mem [DIM][DIM];
  logic signed [BITS_C-1:0]  c_mem [DIM][DIM];
  logic signed [BITS_C-1:0]  acc_next;

  assign i_idx    = ctr[CW-1:2*IW];
  assign j_idx    = ctr[2*IW-1:IW];
  assign k_idx    = ctr[IW-1:0];
  assign last_mac = (state == RUN) && (&ctr);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      ctr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      ctr    <= (state == RUN) ? ctr + CW'(1) : '0;
      done_q <= last_mac;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start_i) state_next = RUN;
      RUN:     if (last_mac) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  tpu_mac #(
    .BITS_AB (BITS_AB),
    .BITS_C  (BITS_C)
  ) u_mac (
    .a        (a_mem[i_idx][k_idx]),
    .b        (b_mem[k_idx][j_idx]),
    .acc      (c_mem[i_idx][j_idx]),
    .acc_next (acc_next)
  );

  // Storage is never reset; host writes are locked out while the sequencer owns C.
  always_ff @(posedge clk_i) begin
    if (state == RUN) begin
      c_mem[i_idx][j_idx] <= acc_next;
    end else begin
      if (bus.wr_en_a_i) a_mem[bus.row_i][bus.col_i] <= bus.data_i[BITS_AB-1:0];
      if (bus.wr_en_b_i) b_mem[bus.row_i][bus.col_i] <= bus.data_i[BITS_AB-1:0];
      if (bus.wr_en_c_i) c_mem[bus.row_i][bus.col_i] <= bus.data_i[BITS_C-1:0];
    end
  end

  assign bus.data_o = 32'(c_mem[bus.row_i][bus.col_i]);
  assign bus.done_o = done_q;
  assign bus.busy_o = (state == RUN);

endmodule

// File: tb/tb_tpu_mac_engine.sv
// Randomised and directed checks of the MAC engine against a plain-arithmetic matrix model.
module tb_tpu_mac_engine;

  localparam int DIM = 2;
  localparam int IW  = $clog2(DIM);
  localparam int N   = DIM * DIM * DIM;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_mac_engine_if #(.DIM(DIM)) bus ();

  tpu_mac_engine #(
    .BITS_AB (16),
    .BITS_C  (32),
    .DIM     (DIM)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  int ma [DIM][DIM];
  int mb [DIM][DIM];
  int mc [DIM][DIM];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: apply the first 'macs' multiply-accumulates in i, j, k order.
  function automatic void model_run(input int macs);
    int n = 0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        for (int k = 0; k < DIM; k++) begin
          if (n < macs) mc[i][j] = mc[i][j] + ma[i][k] * mb[k][j];
          n++;
        end
  endfunction

  task automatic wr_elem(input bit wa, input bit wb, input bit wc,
                         input int r, input int c, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en_a_i = wa;
    bus.wr_en_b_i = wb;
    bus.wr_en_c_i = wc;
    bus.row_i     = IW'(r);
    bus.col_i     = IW'(c);
    bus.data_i    = d;
    if (wa) ma[r][c] = int'(signed'(d[15:0]));
    if (wb) mb[r][c] = int'(signed'(d[15:0]));
    if (wc) mc[r][c] = int'(d);
    @(negedge clk);
    bus.wr_en_a_i = 1'b0;
    bus.wr_en_b_i = 1'b0;
    bus.wr_en_c_i = 1'b0;
  endtask

  task automatic rd(input int r, input int c, output logic [31:0] v);
    bus.row_i = IW'(r);
    bus.col_i = IW'(c);
    #1 v = bus.data_o;
  endtask

  task automatic check_c(input string tag);
    logic [31:0] v;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        rd(r, c, v);
        chk_eq($sformatf("%s_c%0d%0d", tag, r, c), v, mc[r][c]);
      end
  endtask

  task automatic clear_all();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wr_elem(1, 1, 1, r, c, 32'd0);
  endtask

  task automatic load_basic();
    wr_elem(1, 1, 1, 0, 0, 32'd0);
    wr_elem(1, 0, 0, 0, 0, 32'd1); wr_elem(1, 0, 0, 0, 1, 32'd2);
    wr_elem(1, 0, 0, 1, 0, 32'd3); wr_elem(1, 0, 0, 1, 1, 32'd4);
    wr_elem(0, 1, 0, 0, 0, 32'd5); wr_elem(0, 1, 0, 0, 1, 32'd6);
    wr_elem(0, 1, 0, 1, 0, 32'd7); wr_elem(0, 1, 0, 1, 1, 32'd8);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wr_elem(0, 0, 1, r, c, 32'd0);
  endtask

  // Counts edges after the current point until done is seen (bounded).
  task automatic wait_done(input string tag, output int cnt);
    bit seen = 0;
    cnt = 0;
    while (!seen && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.done_o) seen = 1;
    end
    chk_eq({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic run_once(input string tag);
    int cnt;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    chk_eq({tag, "_busy"}, bus.busy_o, 1'b1);
    chk_eq({tag, "_no_early_done"}, bus.done_o, 1'b0);
    wait_done(tag, cnt);
    chk_eq({tag, "_latency"}, cnt + 1, N + 1);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk_eq({tag, "_done_width"}, bus.done_o, 1'b0);
    chk_eq({tag, "_idle_busy"}, bus.busy_o, 1'b0);
    model_run(N);
  endtask

  initial begin
    logic [31:0] v;
    int cnt, cyc, d1, d2;
    bit any_done;

    bus.start_i   = 1'b0;
    bus.wr_en_a_i = 1'b0;
    bus.wr_en_b_i = 1'b0;
    bus.wr_en_c_i = 1'b0;
    bus.row_i     = '0;
    bus.col_i     = '0;
    bus.data_i    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_busy", bus.busy_o, 1'b0);
    chk_eq("rst_done", bus.done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and accumulate
    load_basic();
    run_once("basic");
    check_c("basic");
    rd(0, 0, v); chk_eq("basic_c00_const", v, 32'd19);
    rd(1, 1, v); chk_eq("basic_c11_const", v, 32'd50);
    run_once("accum");
    check_c("accum");
    rd(1, 0, v); chk_eq("accum_c10_const", v, 32'd86);

    // Read-during-write shows pre-edge contents
    @(negedge clk);
    bus.wr_en_c_i = 1'b1;
    bus.row_i     = '0;
    bus.col_i     = '0;
    bus.data_i    = 32'h0000_1234;
    #1 chk_eq("rdw_old", bus.data_o, mc[0][0]);
    @(posedge clk); #1;
    chk_eq("rdw_new", bus.data_o, 32'h0000_1234);
    bus.wr_en_c_i = 1'b0;
    mc[0][0] = 32'h0000_1234;

    // Signed product
    clear_all();
    wr_elem(1, 0, 0, 0, 0, 32'h0000_FFFF);
    wr_elem(0, 1, 0, 0, 0, 32'd3);
    run_once("signed");
    check_c("signed");
    rd(0, 0, v); chk_eq("signed_c00_const", v, 32'hFFFF_FFFD);

    // Accumulator wrap
    clear_all();
    wr_elem(1, 1, 1, 0, 0, 32'd1);
    wr_elem(0, 0, 1, 0, 0, 32'h7FFF_FFFF);
    run_once("wrap");
    rd(0, 0, v); chk_eq("wrap_c00_const", v, 32'h8000_0000);
    check_c("wrap");

    // Writes during RUN are ignored
    load_basic();
    @(negedge clk);
    bus.start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.wr_en_c_i = 1'b1;
    bus.row_i     = '0;
    bus.col_i     = '0;
    bus.data_i    = 32'h0000_DEAD;
    @(posedge clk); #1;
    bus.wr_en_c_i = 1'b0;
    wait_done("runwr", cnt);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    model_run(N);
    check_c("runwr");

    // Asynchronous reset after three MACs
    load_basic();
    @(negedge clk);
    bus.start_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk_eq("midrst_busy", bus.busy_o, 1'b0);
    chk_eq("midrst_done", bus.done_o, 1'b0);
    model_run(3);
    check_c("midrst_partial");
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) any_done = 1;
    end
    chk_eq("midrst_quiet", any_done, 1'b0);
    run_once("postrst");
    check_c("postrst");

    // Back-to-back with start held
    load_basic();
    @(negedge clk);
    bus.start_i = 1'b1;
    cyc = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done_o) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    bus.start_i = 1'b0;
    chk_eq("b2b_first", d1, N + 1);
    chk_eq("b2b_gap", d2 - d1, N + 2);
    model_run(N);
    model_run(N);
    check_c("b2b");
    @(posedge clk); #1;

    // Randomised operands, including simultaneous A/B/C writes
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          wr_elem(1, 1, 1, r, c, $urandom);
          if ($urandom_range(0, 1) == 1) wr_elem(1, 0, 0, r, c, $urandom);
          if ($urandom_range(0, 1) == 1) wr_elem(0, 1, 0, r, c, $urandom);
          if ($urandom_range(0, 1) == 1) wr_elem(0, 0, 1, r, c, $urandom);
        end
      run_once($sformatf("rand%0d", it));
      check_c($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
